bit_window_aligner: RTL

- Upstream bitstream front-end for the coeff_token decoders.
- Accepts MSB-first 32-bit slice-data words and keeps a 64-bit left-aligned bit buffer.
- Presents a registered 16-bit look-ahead window (Bits) to the CoeffTokenLUT tables.
- Consumes the NumShift they return, so a new token window is available every cycle at full throughput.

---
 rtl/cavlc_pkg.sv | 15 +
 rtl/bit_window_merge.sv | 31 +++
 rtl/bit_window_aligner.sv | 102 ++++++++++
 3 files changed

// File: rtl/cavlc_pkg.sv
// Shared widths and small types for the CAVLC bitstream front-end.
package cavlc_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BUF_W     = 2 * WORD_W;
  localparam int unsigned WIN_W     = 16;
  localparam int unsigned MAX_SHIFT = 16;
  localparam int unsigned SHIFT_W   = 5;
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned POS_W     = 32;

  typedef logic [SHIFT_W-1:0] shift_t;
  typedef logic [CNT_W-1:0]   bitcnt_t;

endpackage : cavlc_pkg

// File: rtl/bit_window_merge.sv
// Next-state merge for the left-aligned bit buffer.
// Ports:
//   buf_cur  - current buffer, bit BUF_W-1 is the next unconsumed bit
//   s        - effective shift applied this cycle
//   r        - bits remaining after the shift (placement point of the new word)
//   data     - incoming stream word, MSB first
//   load     - a word is accepted this cycle
//   buf_nxt  - buffer value for the next edge
module bit_window_merge
  import cavlc_pkg::*;
(
  input  logic [BUF_W-1:0]  buf_cur,
  input  shift_t            s,
  input  bitcnt_t           r,
  input  logic [WORD_W-1:0] data,
  input  logic              load,
  output logic [BUF_W-1:0]  buf_nxt
);

  logic [BUF_W-1:0] word_ext;

  // Drop consumed bits, then append the new word directly after the survivors.
  always_comb begin
    word_ext = {data, {WORD_W{1'b0}}};
    buf_nxt  = buf_cur << s;
    if (load) begin
      buf_nxt = buf_nxt | (word_ext >> r);
    end
  end

endmodule : bit_window_merge

// File: rtl/bit_window_aligner.sv
// 64-bit left-aligned bit buffer presenting a 16-bit look-ahead window to the
// coeff_token LUTs and consuming their shift amount each cycle.
// Ports:
//   Clk, nReset         - clock, async active-low reset
//   InData/InValid/InLast/InReady - MSB-first 32-bit word input handshake
//   Flush               - synchronous clear of all stream state
//   Bits/BitsValid      - registered window, bit 15 is the next bit
//   Shift/ShiftEn       - bits consumed this cycle (0..16)
//   BitsLeft            - valid bits held in the buffer
//   BitPos              - running count of consumed bits (wraps)
//   ShiftErr            - sticky illegal-shift flag
module bit_window_aligner
  import cavlc_pkg::*;
(
  input  logic               Clk,
  input  logic               nReset,
  input  logic [WORD_W-1:0]  InData,
  input  logic               InValid,
  input  logic               InLast,
  output logic               InReady,
  input  logic               Flush,
  output logic [WIN_W-1:0]   Bits,
  output logic               BitsValid,
  input  logic [SHIFT_W-1:0] Shift,
  input  logic               ShiftEn,
  output logic [CNT_W-1:0]   BitsLeft,
  output logic [POS_W-1:0]   BitPos,
  output logic               ShiftErr
);

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_nxt;
  bitcnt_t          cnt_q;
  bitcnt_t          cnt_nxt;
  bitcnt_t          rem;
  shift_t           s_eff;
  logic             eos_q;
  logic             eos_nxt;
  logic             valid_q;
  logic             valid_nxt;
  logic             err_q;
  logic             shift_ok;
  logic             load;
  logic [POS_W-1:0] bit_pos_q;

  // Shift legality, handshake and next count/flags.
  always_comb begin
    shift_ok  = ShiftEn & valid_q &
                (Shift <= SHIFT_W'(MAX_SHIFT)) &
                (CNT_W'(Shift) <= cnt_q);
    s_eff     = shift_ok ? Shift : '0;
    rem       = cnt_q - CNT_W'(s_eff);
    // Same-cycle shift frees space, so readiness looks at the post-shift count.
    InReady   = ~eos_q & (rem <= CNT_W'(WORD_W));
    load      = InValid & InReady;
    cnt_nxt   = load ? (rem + CNT_W'(WORD_W)) : rem;
    eos_nxt   = eos_q | (load & InLast);
    valid_nxt = (cnt_nxt >= CNT_W'(WIN_W)) | (eos_nxt & (cnt_nxt != '0));
  end

  bit_window_merge u_merge (
    .buf_cur (buf_q),
    .s       (s_eff),
    .r       (rem),
    .data    (InData),
    .load    (load),
    .buf_nxt (buf_nxt)
  );

  // State registers; Flush outranks every other input.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      buf_q     <= '0;
      cnt_q     <= '0;
      eos_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      bit_pos_q <= '0;
    end else if (Flush) begin
      buf_q     <= '0;
      cnt_q     <= '0;
      eos_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      bit_pos_q <= '0;
    end else begin
      buf_q     <= buf_nxt;
      cnt_q     <= cnt_nxt;
      eos_q     <= eos_nxt;
      valid_q   <= valid_nxt;
      err_q     <= err_q | (ShiftEn & ~shift_ok);
      bit_pos_q <= bit_pos_q + POS_W'(s_eff);
    end
  end

  assign Bits      = buf_q[BUF_W-1 -: WIN_W];
  assign BitsValid = valid_q;
  assign BitsLeft  = cnt_q;
  assign BitPos    = bit_pos_q;
  assign ShiftErr  = err_q;

endmodule : bit_window_aligner
